// File: rtl/lsu_pkg.sv
// rtl/lsu_pkg.sv - shared state encoding, funct3 codes and legality check for the LSU
package lsu_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    WRITE = 2'd2,
    RESP  = 2'd3
  } lsu_state_e;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  function automatic logic is_legal_funct3(input logic store, input logic [2:0] funct3);
    logic legal;
    legal = 1'b0;
    case (funct3)
      F3_B, F3_H, F3_W: legal = 1'b1;
      F3_BU, F3_HU:     legal = !store;
      default:          legal = 1'b0;
    endcase
    return legal;
  endfunction

endpackage

// File: rtl/lsu_lane_align.sv
// rtl/lsu_lane_align.sv - byte/half lane merge for sub-word stores and load extension
module lsu_lane_align
  import lsu_pkg::*;
(
  input  logic [2:0]  i_funct3,
  input  logic [1:0]  i_addr_lo,
  input  logic [31:0] i_old_word,
  input  logic [31:0] i_store_data,
  input  logic [31:0] i_read_word,
  output logic [31:0] o_merged_word,
  output logic [31:0] o_load_value
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;

  always_comb begin
    o_merged_word = i_old_word;
    case (i_funct3[1:0])
      2'b00: begin
        case (i_addr_lo)
          2'd0:    o_merged_word[7:0]   = i_store_data[7:0];
          2'd1:    o_merged_word[15:8]  = i_store_data[7:0];
          2'd2:    o_merged_word[23:16] = i_store_data[7:0];
          default: o_merged_word[31:24] = i_store_data[7:0];
        endcase
      end
      2'b01: begin
        if (i_addr_lo[1]) o_merged_word[31:16] = i_store_data[15:0];
        else              o_merged_word[15:0]  = i_store_data[15:0];
      end
      default: o_merged_word = i_store_data;
    endcase
  end

  always_comb begin
    case (i_addr_lo)
      2'd0:    w_byte = i_read_word[7:0];
      2'd1:    w_byte = i_read_word[15:8];
      2'd2:    w_byte = i_read_word[23:16];
      default: w_byte = i_read_word[31:24];
    endcase
    w_half = i_addr_lo[1] ? i_read_word[31:16] : i_read_word[15:0];
    case (i_funct3)
      F3_B:    o_load_value = {{24{w_byte[7]}}, w_byte};
      F3_BU:   o_load_value = {24'd0, w_byte};
      F3_H:    o_load_value = {{16{w_half[15]}}, w_half};
      F3_HU:   o_load_value = {16'd0, w_half};
      default: o_load_value = i_read_word;
    endcase
  end

endmodule

// File: rtl/lsu_dm_master.sv
// rtl/lsu_dm_master.sv - RV32I load/store master for the DM port with read-modify-write sub-word stores
// LSU_MISALIGN_FAULT_EN: misaligned half/word accesses fault instead of being force-aligned.
module lsu_dm_master
  import lsu_pkg::*;
#(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_store,
  input  logic [2:0]        req_funct3,
  input  logic [31:0]       req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [DATA_W-1:0] resp_rdata,
  output logic              resp_fault,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wd,
  input  logic [DATA_W-1:0] mem_rd
);

  lsu_state_e        r_state, w_next;
  logic              r_store;
  logic [2:0]        r_funct3;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_wdata, r_word, r_rdata;
  logic              r_fault;
  logic [ADDR_W-1:0] r_mem_addr;
  logic [DATA_W-1:0] r_mem_wd;

  logic              w_accept, w_legal, w_misaligned, w_fault;
  logic [ADDR_W-1:0] w_addr_aligned, w_word_addr;
  logic [DATA_W-1:0] w_merged, w_load_value;
  logic              w_unused_addr_hi;

  assign w_unused_addr_hi = ^req_addr[31:ADDR_W];
  assign w_accept    = req_valid && (r_state == IDLE);
  assign w_legal     = is_legal_funct3(req_store, req_funct3);
  assign w_misaligned = ((req_funct3[1:0] == 2'b01) && req_addr[0]) ||
                        ((req_funct3[1:0] == 2'b10) && (req_addr[1:0] != 2'b00));
`ifdef LSU_MISALIGN_FAULT_EN
  assign w_fault = !w_legal || w_misaligned;
`else
  assign w_fault = !w_legal;
`endif
  assign w_word_addr = {r_addr[ADDR_W-1:2], 2'b00};

  // Without the fault option, misaligned accesses drop to natural alignment
  always_comb begin
    w_addr_aligned = req_addr[ADDR_W-1:0];
    if (req_funct3[1:0] == 2'b01) w_addr_aligned[0] = 1'b0;
    else if (req_funct3[1:0] == 2'b10) w_addr_aligned[1:0] = 2'b00;
  end

  lsu_lane_align u_align (
    .i_funct3     (r_funct3),
    .i_addr_lo    (r_addr[1:0]),
    .i_old_word   (r_word),
    .i_store_data (r_wdata),
    .i_read_word  (mem_rd),
    .o_merged_word(w_merged),
    .o_load_value (w_load_value)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= IDLE;
      r_store    <= 1'b0;
      r_funct3   <= 3'd0;
      r_addr     <= '0;
      r_wdata    <= '0;
      r_word     <= '0;
      r_rdata    <= '0;
      r_fault    <= 1'b0;
      r_mem_addr <= '0;
      r_mem_wd   <= '0;
    end else begin
      r_state <= w_next;
      if (w_accept) begin
        r_store  <= req_store;
        r_funct3 <= req_funct3;
        r_addr   <= w_addr_aligned;
        r_wdata  <= req_wdata;
        r_fault  <= w_fault;
        r_rdata  <= '0;
      end
      if (r_state == READ) begin
        r_word <= mem_rd;
        if (!r_store) r_rdata <= w_load_value;
      end
      if (r_state == READ || r_state == WRITE) r_mem_addr <= w_word_addr;
      if (r_state == WRITE) r_mem_wd <= w_merged;
    end
  end

  always_comb begin
    w_next     = r_state;
    req_ready  = 1'b0;
    resp_valid = 1'b0;
    mem_we     = 1'b0;
    mem_addr   = r_mem_addr;
    mem_wd     = r_mem_wd;
    case (r_state)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          if (w_fault) w_next = RESP;
          else if (req_store && req_funct3 == F3_W) w_next = WRITE;
          else w_next = READ;
        end
      end
      READ: begin
        mem_addr = w_word_addr;
        w_next   = r_store ? WRITE : RESP;
      end
      WRITE: begin
        mem_we   = 1'b1;
        mem_addr = w_word_addr;
        mem_wd   = w_merged;
        w_next   = RESP;
      end
      default: begin
        resp_valid = 1'b1;
        if (resp_ready) w_next = IDLE;
      end
    endcase
  end

  assign resp_rdata = r_rdata;
  assign resp_fault = r_fault;

endmodule

// File: tb/tb_lsu_dm_master.sv
// tb/tb_lsu_dm_master.sv - directed self-checking bench for lsu_dm_master with a behavioural DM
module tb_lsu_dm_master;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid, req_ready, req_store;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr, req_wdata;
  logic        resp_valid, resp_ready;
  logic [31:0] resp_rdata;
  logic        resp_fault;
  logic        mem_we;
  logic [15:0] mem_addr;
  logic [31:0] mem_wd, mem_rd;

  logic [31:0] mem [0:16383];
  int          we_count = 0;
  logic [15:0] last_wa = '0;
  logic [31:0] last_wd = '0;
  int          checks = 0;
  int          errors = 0;

  always #5 clk = ~clk;

  lsu_dm_master #(.ADDR_W(16), .DATA_W(32)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_store (req_store),
    .req_funct3(req_funct3),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .resp_valid(resp_valid),
    .resp_ready(resp_ready),
    .resp_rdata(resp_rdata),
    .resp_fault(resp_fault),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wd    (mem_wd),
    .mem_rd    (mem_rd)
  );

  assign mem_rd = mem[mem_addr[15:2]];

  always @(posedge clk) begin
    if (mem_we) begin
      mem[mem_addr[15:2]] <= mem_wd;
      we_count <= we_count + 1;
      last_wa  <= mem_addr;
      last_wd  <= mem_wd;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic do_req(input logic st, input logic [2:0] f3, input logic [31:0] a,
                        input logic [31:0] wd, input bit ack,
                        output int lat, output logic [31:0] rd, output logic flt);
    @(negedge clk);
    req_valid = 1'b1; req_store = st; req_funct3 = f3; req_addr = a; req_wdata = wd;
    @(posedge clk); #1;
    req_valid = 1'b0;
    lat = 1;
    while (!resp_valid && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    if (!resp_valid) check("resp_timeout", {31'd0, resp_valid}, 32'd1);
    rd  = resp_rdata;
    flt = resp_fault;
    if (ack) begin
      resp_ready = 1'b1;
      @(posedge clk); #1;
      resp_ready = 1'b0;
    end
  endtask

  task automatic txn(input string tag, input logic st, input logic [2:0] f3, input logic [31:0] a,
                     input logic [31:0] wd, input int exp_lat, input logic [31:0] exp_rd,
                     input logic exp_flt);
    int          lat;
    logic [31:0] rd;
    logic        flt;
    do_req(st, f3, a, wd, 1'b1, lat, rd, flt);
    check({tag, "_lat"}, lat, exp_lat);
    check({tag, "_rdata"}, rd, exp_rd);
    check({tag, "_fault"}, {31'd0, flt}, {31'd0, exp_flt});
  endtask

  initial begin
    int          wc, lat;
    logic [31:0] rd;
    logic        flt;
    rst = 1'b1; req_valid = 1'b0; req_store = 1'b0; req_funct3 = 3'd0;
    req_addr = '0; req_wdata = '0; resp_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("rst_req_ready", {31'd0, req_ready}, 32'd1);
    check("rst_resp_valid", {31'd0, resp_valid}, 32'd0);
    check("rst_resp_rdata", resp_rdata, 32'd0);
    check("rst_resp_fault", {31'd0, resp_fault}, 32'd0);
    check("rst_mem_we", {31'd0, mem_we}, 32'd0);
    check("rst_mem_addr", {16'd0, mem_addr}, 32'd0);
    check("rst_mem_wd", mem_wd, 32'd0);

    wc = we_count;
    txn("sw", 1'b1, 3'b010, 32'h0000_0104, 32'hDEAD_BEEF, 2, 32'd0, 1'b0);
    check("sw_we_pulses", we_count - wc, 32'd1);
    check("sw_addr", {16'd0, last_wa}, 32'h0104);
    check("sw_wd", last_wd, 32'hDEAD_BEEF);

    txn("sw_init", 1'b1, 3'b010, 32'h0000_0104, 32'h80FF_1234, 2, 32'd0, 1'b0);
    wc = we_count;
    txn("lb", 1'b0, 3'b000, 32'h0000_0107, 32'd0, 2, 32'hFFFF_FF80, 1'b0);
    txn("lbu", 1'b0, 3'b100, 32'h0000_0107, 32'd0, 2, 32'h0000_0080, 1'b0);
    txn("lh", 1'b0, 3'b001, 32'h0000_0106, 32'd0, 2, 32'hFFFF_80FF, 1'b0);
    txn("lhu", 1'b0, 3'b101, 32'h0000_0106, 32'd0, 2, 32'h0000_80FF, 1'b0);
    txn("lh_lo", 1'b0, 3'b001, 32'h0000_0104, 32'd0, 2, 32'h0000_1234, 1'b0);
    txn("lw", 1'b0, 3'b010, 32'h0000_0104, 32'd0, 2, 32'h80FF_1234, 1'b0);
    txn("lw_trunc", 1'b0, 3'b010, 32'hFFFF_0104, 32'd0, 2, 32'h80FF_1234, 1'b0);
    check("loads_no_we", we_count - wc, 32'd0);

    txn("sw_init2", 1'b1, 3'b010, 32'h0000_0100, 32'h1122_3344, 2, 32'd0, 1'b0);
    txn("sh", 1'b1, 3'b001, 32'h0000_0102, 32'h0000_ABCD, 3, 32'd0, 1'b0);
    check("sh_wd", last_wd, 32'hABCD_3344);
    check("sh_addr", {16'd0, last_wa}, 32'h0100);
    txn("sw_init3", 1'b1, 3'b010, 32'h0000_0100, 32'h1122_3344, 2, 32'd0, 1'b0);
    txn("sb", 1'b1, 3'b000, 32'h0000_0101, 32'h0000_0077, 3, 32'd0, 1'b0);
    check("sb_wd", last_wd, 32'h1122_7744);

    wc = we_count;
`ifdef LSU_MISALIGN_FAULT_EN
    txn("lw_mis", 1'b0, 3'b010, 32'h0000_0102, 32'd0, 1, 32'd0, 1'b1);
    txn("lh_mis", 1'b0, 3'b001, 32'h0000_0105, 32'd0, 1, 32'd0, 1'b1);
    txn("sh_mis", 1'b1, 3'b001, 32'h0000_0101, 32'h0000_5555, 1, 32'd0, 1'b1);
`else
    txn("lw_mis", 1'b0, 3'b010, 32'h0000_0102, 32'd0, 2, 32'h1122_7744, 1'b0);
    txn("lh_mis", 1'b0, 3'b001, 32'h0000_0105, 32'd0, 2, 32'h0000_1234, 1'b0);
`endif
    txn("ld_f3_110", 1'b0, 3'b110, 32'h0000_0104, 32'd0, 1, 32'd0, 1'b1);
    txn("st_f3_011", 1'b1, 3'b011, 32'h0000_0104, 32'h0000_0000, 1, 32'd0, 1'b1);
    check("fault_no_we", we_count - wc, 32'd0);

    do_req(1'b0, 3'b010, 32'h0000_0104, 32'd0, 1'b0, lat, rd, flt);
    check("hold_rdata0", rd, 32'h80FF_1234);
    req_valid = 1'b1; req_store = 1'b0; req_funct3 = 3'b010; req_addr = 32'h0000_0100;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      check("hold_valid", {31'd0, resp_valid}, 32'd1);
      check("hold_rdata", resp_rdata, 32'h80FF_1234);
      check("hold_fault", {31'd0, resp_fault}, 32'd0);
      check("hold_req_ready", {31'd0, req_ready}, 32'd0);
    end
    req_valid = 1'b0;
    resp_ready = 1'b1;
    @(posedge clk); #1;
    resp_ready = 1'b0;
    check("post_hs_valid", {31'd0, resp_valid}, 32'd0);
    check("post_hs_ready", {31'd0, req_ready}, 32'd1);

    wc = we_count;
    @(negedge clk);
    req_valid = 1'b1; req_store = 1'b1; req_funct3 = 3'b000;
    req_addr = 32'h0000_0105; req_wdata = 32'h0000_0055;
    @(posedge clk); #1;
    req_valid = 1'b0;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("abort_ready", {31'd0, req_ready}, 32'd1);
    check("abort_valid", {31'd0, resp_valid}, 32'd0);
    repeat (3) @(posedge clk);
    #1;
    check("abort_valid_later", {31'd0, resp_valid}, 32'd0);
    check("abort_no_we", we_count - wc, 32'd0);
    txn("lw_after_abort", 1'b0, 3'b010, 32'h0000_0104, 32'd0, 2, 32'h80FF_1234, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
